// File: rtl/mcu_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_rst_pkg
//  Description : Shared types and constants for the MCU reset controller:
//                FSM state encoding, reset-cause bit positions and default
//                timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_rst_pkg;

    // Reset sequencing states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_REL = 2'd2
    } rst_state_t;

    // Bit positions inside rst_cause
    localparam int unsigned CAUSE_POR = 0;
    localparam int unsigned CAUSE_BTN = 1;
    localparam int unsigned CAUSE_WDT = 2;

    // Default timing: debounce window and reset pulse length, in clock cycles
    localparam logic [15:0] DEF_DEB_CYCLES   = 16'd50000;
    localparam logic [7:0]  DEF_PULSE_CYCLES = 8'd32;

endpackage : mcu_rst_pkg
`default_nettype wire

// File: rtl/rst_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : rst_debounce
//  Description : Two-flop synchronizer and stability-window debouncer for the
//                external active-low reset button. Emits the debounced level
//                and a one-cycle pulse when the button becomes pressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_debounce
    import mcu_rst_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pad_rst_btn_b,
    output logic btn_stable,
    output logic btn_press
);

    logic [1:0]  btn_sync;
    logic [15:0] deb_cnt;

    // Bring the asynchronous pad into the clock domain; reset to "released"
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            btn_sync <= 2'b11;
        end else begin
            btn_sync <= {btn_sync[0], pad_rst_btn_b};
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES cycles in a row;
    // a press pulse is raised only when the accepted level goes from released to pressed
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            btn_stable <= 1'b1;
            deb_cnt    <= 16'd0;
            btn_press  <= 1'b0;
        end else begin
            btn_press <= 1'b0;
            if (btn_sync[1] == btn_stable) begin
                deb_cnt <= 16'd0;
            end else if (deb_cnt == DEB_CYCLES - 16'd1) begin
                btn_stable <= btn_sync[1];
                deb_cnt    <= 16'd0;
                btn_press  <= btn_stable;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end
    end

endmodule : rst_debounce
`default_nettype wire

// File: rtl/mcu_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_rst_ctrl
//  Description : MCU reset controller. Combines power-on, debounced button
//                and watchdog requests into a fixed-length registered
//                active-low reset pulse (stretched while the button is held)
//                and keeps a sticky record of what caused it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_rst_ctrl
    import mcu_rst_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter logic [7:0]  PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pad_rst_btn_b,
    input  logic       wdt_rst_req,
    input  logic       cause_clr,
    output logic       mcu_rst_signal,
    output logic [2:0] rst_cause,
    output logic       rst_busy
);

    logic       btn_stable;
    logic       btn_press;
    rst_state_t state;
    logic [7:0] pulse_cnt;
    logic [2:0] cause_set;

    rst_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .pad_rst_btn_b (pad_rst_btn_b),
        .btn_stable    (btn_stable),
        .btn_press     (btn_press)
    );

    // Reset sequencer; output is registered alongside the state so it cannot glitch.
    // Requests seen outside ST_RUN are ignored here and only logged as causes.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state          <= ST_ASSERT;
            pulse_cnt      <= 8'd0;
            mcu_rst_signal <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (btn_press || wdt_rst_req) begin
                        state          <= ST_ASSERT;
                        pulse_cnt      <= 8'd0;
                        mcu_rst_signal <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (pulse_cnt == PULSE_CYCLES - 8'd1) begin
                        pulse_cnt <= 8'd0;
                        if (btn_stable) begin
                            state          <= ST_RUN;
                            mcu_rst_signal <= 1'b1;
                        end else begin
                            state <= ST_WAIT_REL;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + 8'd1;
                    end
                end
                ST_WAIT_REL: begin
                    if (btn_stable) begin
                        state          <= ST_RUN;
                        mcu_rst_signal <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_ASSERT;
                    pulse_cnt      <= 8'd0;
                    mcu_rst_signal <= 1'b0;
                end
            endcase
        end
    end

    // Busy mirrors the registered reset output exactly
    assign rst_busy = ~mcu_rst_signal;

    // Cause bits requested this cycle
    always_comb begin
        cause_set            = 3'b000;
        cause_set[CAUSE_BTN] = btn_press;
        cause_set[CAUSE_WDT] = wdt_rst_req;
    end

    // Sticky cause register; a same-cycle set beats a clear for that bit
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rst_cause            <= 3'b000;
            rst_cause[CAUSE_POR] <= 1'b1;
        end else if (cause_clr) begin
            rst_cause <= cause_set;
        end else begin
            rst_cause <= rst_cause | cause_set;
        end
    end

endmodule : mcu_rst_ctrl
`default_nettype wire

// File: tb/tb_mcu_rst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_rst_ctrl
//  Description : Self-checking bench for mcu_rst_ctrl (DEB_CYCLES=4,
//                PULSE_CYCLES=8). Stimulus tasks push the expected reset
//                pulse window and cause; a monitor checks every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_rst_ctrl;

    localparam int DEB   = 4;
    localparam int PULSE = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       pad_rst_btn_b;
    logic       wdt_rst_req;
    logic       cause_clr;
    logic       mcu_rst_signal;
    logic [2:0] rst_cause;
    logic       rst_busy;

    mcu_rst_ctrl #(
        .DEB_CYCLES   (16'd4),
        .PULSE_CYCLES (8'd8)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .pad_rst_btn_b  (pad_rst_btn_b),
        .wdt_rst_req    (wdt_rst_req),
        .cause_clr      (cause_clr),
        .mcu_rst_signal (mcu_rst_signal),
        .rst_cause      (rst_cause),
        .rst_busy       (rst_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // One expected reset pulse: low from cycle 'start' up to (not incl.) 'stop'
    typedef struct {
        int         start;
        int         stop;
        logic [2:0] cause;
    } pulse_t;

    pulse_t     exp_q[$];
    int         cyc     = 0;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_cause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    // Monitor: cyc = index of the most recent rising edge
    initial begin : monitor
        logic exp_low;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            exp_low = (exp_q.size() > 0) && (cyc >= exp_q[0].start) && (cyc < exp_q[0].stop);
            check("mcu_rst_signal", {31'd0, mcu_rst_signal}, {31'd0, ~exp_low});
            check("rst_busy", {31'd0, rst_busy}, {31'd0, exp_low});
            if (exp_q.size() > 0 && cyc == exp_q[0].stop) begin
                check("rst_cause_at_pulse_end", {29'd0, rst_cause}, {29'd0, exp_cause_of_head()});
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [2:0] exp_cause_of_head();
        return exp_q[0].cause;
    endfunction

    // Watchdog request; optional prior clear; optional extra request (and clear)
    // d cycles into the pulse, which must not stretch it
    task automatic sc_wdt(input bit do_clr, input int d, input bit d_clr);
        int         z;
        logic [2:0] c;
        c = exp_cause;
        if (do_clr) begin
            cause_clr = 1'b1;
            step();
            cause_clr = 1'b0;
            c = 3'b000;
        end
        c = c | 3'b100;
        if (d > 0 && d_clr) c = 3'b100;
        z = cyc + 1;
        exp_q.push_back('{start: z, stop: z + PULSE, cause: c});
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        if (d > 0) begin
            while (cyc < z + d - 1) step();
            wdt_rst_req = 1'b1;
            cause_clr   = d_clr;
            step();
            wdt_rst_req = 1'b0;
            cause_clr   = 1'b0;
        end
        while (cyc < z + PULSE + 2) step();
        exp_cause = c;
    endtask

    // Bouncy button press/hold/release; optional watchdog+clear in the press cycle
    task automatic sc_btn(input bit do_clr, input int nb_fall, input int hold,
                          input int nb_rel, input bit with_wdt, input bit fixed2);
        logic       seq[$];
        int         k_off, j_off, t0, k, j, zero, e, r;
        logic [2:0] c;
        for (int i = 0; i < nb_fall; i++) begin
            r = fixed2 ? 2 : int'($urandom_range(1, 3));
            repeat (r) seq.push_back(1'b0);
            r = fixed2 ? 2 : int'($urandom_range(1, 3));
            repeat (r) seq.push_back(1'b1);
        end
        k_off = seq.size();
        repeat (hold) seq.push_back(1'b0);
        for (int i = 0; i < nb_rel; i++) begin
            r = int'($urandom_range(1, 3));
            repeat (r) seq.push_back(1'b1);
            r = int'($urandom_range(1, 3));
            repeat (r) seq.push_back(1'b0);
        end
        j_off = seq.size();
        repeat (14) seq.push_back(1'b1);

        c = exp_cause;
        if (do_clr) begin
            cause_clr = 1'b1;
            step();
            cause_clr = 1'b0;
            c = 3'b000;
        end
        c = with_wdt ? 3'b110 : (c | 3'b010);
        t0   = cyc;
        k    = t0 + k_off;
        j    = t0 + j_off;
        zero = k + 2 + DEB + 1;
        e    = (zero + PULSE > j + 2 + DEB + 1) ? zero + PULSE : j + 2 + DEB + 1;
        exp_q.push_back('{start: zero, stop: e, cause: c});
        for (int i = 0; i < seq.size(); i++) begin
            pad_rst_btn_b = seq[i];
            wdt_rst_req   = with_wdt && (cyc == zero - 1);
            cause_clr     = with_wdt && (cyc == zero - 1);
            step();
        end
        pad_rst_btn_b = 1'b1;
        wdt_rst_req   = 1'b0;
        cause_clr     = 1'b0;
        while (cyc < e + 2) step();
        exp_cause = c;
    endtask

    // Watchdog pulse interrupted by sys_rst while pulse_cnt == 5
    task automatic sc_rst_mid();
        int z;
        z = cyc + 1;
        exp_q.push_back('{start: z, stop: z + 7 + PULSE, cause: 3'b001});
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        while (cyc < z + 5) step();
        sys_rst = 1'b1;
        step();
        check("rst_cause_during_reset", {29'd0, rst_cause}, 32'd1);
        step();
        sys_rst = 1'b0;
        while (cyc < z + 7 + PULSE + 2) step();
        exp_cause = 3'b001;
    endtask

    initial begin : stim
        sys_rst       = 1'b1;
        pad_rst_btn_b = 1'b1;
        wdt_rst_req   = 1'b0;
        cause_clr     = 1'b0;
        exp_cause     = 3'b001;
        // Power-on: reset held for edges 1..3, released before edge 4
        exp_q.push_back('{start: 1, stop: 3 + PULSE, cause: 3'b001});
        step();
        step();
        check("reset_cause", {29'd0, rst_cause}, 32'd1);
        check("reset_busy", {31'd0, rst_busy}, 32'd1);
        step();
        sys_rst = 1'b0;
        while (cyc < 3 + PULSE + 3) step();

        sc_wdt(1'b1, 0, 1'b0);                 // clear then watchdog -> 100
        sc_btn(1'b1, 5, 30, 0, 1'b0, 1'b1);    // 2-cycle bounce, long hold -> 010
        sc_btn(1'b0, 0, 6, 0, 1'b1, 1'b0);     // press + wdt + clear same cycle -> 110
        sc_wdt(1'b1, 4, 1'b0);                 // second wdt at pulse_cnt=3
        sc_rst_mid();                          // reset at pulse_cnt=5

        repeat (16) begin
            if ($urandom_range(0, 1) == 0) begin
                sc_wdt(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            end else begin
                sc_btn(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                       int'($urandom_range(4, 24)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'b0);
            end
            repeat (int'($urandom_range(1, 5))) step();
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : timeout
        #400000;
        n_fail++;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule : tb_mcu_rst_ctrl
`default_nettype wire

// File: doc/mcu_rst_ctrl.md
MCU_RST_CTRL -- requirements
Module: mcu_rst_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16'd50000: button debounce stability window, in sys_clk cycles (>=1).
REQ-002 SHALL have parameter PULSE_CYCLES, default 8'd32: mcu_rst_signal low-pulse length, in cycles (>=2).
REQ-003 SHALL have port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pad_rst_btn_b  in  1  external reset button, asynchronous, active-low, may bounce.
REQ-006 SHALL have port wdt_rst_req  in  1  watchdog reset request, single-cycle pulse, synchronous to sys_clk.
REQ-007 SHALL have port cause_clr  in  1  clears rst_cause, synchronous, one cycle.
REQ-008 SHALL have port mcu_rst_signal  out  1  active-low reset fed to the downstream reset synchronizer/distribution stage; registered.
REQ-009 SHALL have port rst_cause  out  3  sticky reset cause {wdt, btn, por}.
REQ-010 SHALL have port rst_busy  out  1  high while any reset pulse or release-wait is in progress.

Function
REQ-011 SHALL synchronize pad_rst_btn_b through two flops (btn_sync), with reset value 1 (released).
REQ-012 Debounce: btn_stable (reset 1) and deb_cnt (16 bit, reset 0); deb_cnt SHALL clear whenever btn_sync==btn_stable and otherwise increment.
REQ-013 When btn_sync!=btn_stable and deb_cnt==DEB_CYCLES-1, btn_stable SHALL take btn_sync and deb_cnt SHALL clear; any bounce back before that SHALL clear deb_cnt.
REQ-014 btn_press SHALL be a one-cycle pulse on the 1->0 transition of btn_stable; the 0->1 transition produces no event.
REQ-015 The FSM SHALL have exactly three states: ST_RUN, ST_ASSERT and ST_WAIT_REL.
REQ-016 ST_RUN: on btn_press or wdt_rst_req, SHALL go to ST_ASSERT with pulse_cnt=0; mcu_rst_signal SHALL go 0 on the following cycle (1-cycle latency).
REQ-017 ST_ASSERT: pulse_cnt SHALL increment each cycle; at pulse_cnt==PULSE_CYCLES-1, SHALL go to ST_WAIT_REL if btn_stable==0, else to ST_RUN.
REQ-018 mcu_rst_signal SHALL be low for exactly PULSE_CYCLES cycles when the button is not held.
REQ-019 ST_WAIT_REL: SHALL hold mcu_rst_signal=0 until btn_stable==1, then go to ST_RUN.
REQ-020 Requests arriving in ST_ASSERT or ST_WAIT_REL SHALL record their cause only, and SHALL neither extend nor restart the pulse.
REQ-021 mcu_rst_signal SHALL be 0 in ST_ASSERT and ST_WAIT_REL and 1 in ST_RUN, and SHALL be registered and glitch-free.
REQ-022 rst_busy SHALL be 1 exactly when mcu_rst_signal is 0.
REQ-023 rst_cause bit1 SHALL be set on btn_press and bit2 on wdt_rst_req, with both set when the two arrive in the same cycle; bits are sticky.
REQ-024 cause_clr SHALL zero all bits, except that a set in the same cycle wins for that bit.
REQ-025 Worst-case button-to-reset latency SHALL be 2 + DEB_CYCLES + 1 cycles.

Reset
REQ-026 While sys_rst=1: state=ST_ASSERT, pulse_cnt=0, mcu_rst_signal=0, rst_busy=1, btn_sync=2'b11, btn_stable=1, deb_cnt=0, rst_cause=3'b001.
REQ-027 After sys_rst falls, a full PULSE_CYCLES power-on pulse SHALL run; sys_rst asserted mid-pulse SHALL restart it from 0.

Structure
REQ-028 Package mcu_rst_pkg SHALL hold the state enum, the cause bit indices (POR=0, BTN=1, WDT=2) and the default DEB_CYCLES/PULSE_CYCLES values.
REQ-029 Sub-module rst_debounce SHALL contain the synchronizer and debounce logic and output btn_stable and btn_press; the FSM, counter and cause logic stay in mcu_rst_ctrl.

Verification (bench: DEB_CYCLES=4, PULSE_CYCLES=8)
REQ-030 sys_rst=1 for 3 cycles, then 0 -> mcu_rst_signal=0 for 8 cycles after release, then 1; rst_cause=001; rst_busy falls with it.
REQ-031 cause_clr, then wdt_rst_req at cycle N -> mcu_rst_signal=0 for cycles N+1..N+8; rst_cause=100.
REQ-032 Button toggled every 2 cycles for 20 cycles, then held low for 30 cycles, then released -> exactly one pulse.
REQ-033 For REQ-032: the pulse stays low until btn_stable returns to 1, and rst_cause=010 after a prior clear.
REQ-034 btn_press and wdt_rst_req in the same cycle, with cause_clr also asserted -> one 8-cycle pulse; rst_cause=110.
REQ-035 wdt_rst_req at pulse_cnt=3 -> pulse still ends after 8 cycles total; bit2 set.
REQ-036 sys_rst asserted at pulse_cnt=5 -> pulse restarts and runs 8 full cycles after release; rst_cause=001.
